// File: rtl/bob_except_banked.sv
// Banked exception-info store for the retire buffer. One row per retire bundle,
// one bank per instruction slot. Execution ports post single records, the
// allocator initialises whole rows, retire reads one latched row.

`ifndef EXCEPT_WIDTH
`define EXCEPT_WIDTH 16
`endif

module bob_except_banked #(
    parameter int DATA_WIDTH = `EXCEPT_WIDTH,
    parameter int BANKS      = 10,
    parameter int ROW_W      = 6,
    parameter int BANK_W     = 4,
    parameter int WPORTS     = 9,
    parameter int READ_REG   = 0
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [WPORTS-1:0]             wr_en,
    input  logic [WPORTS*(ROW_W+BANK_W)-1:0] wr_addr,
    input  logic [WPORTS*DATA_WIDTH-1:0]  wr_data,
    input  logic                          init_en,
    input  logic [ROW_W-1:0]              init_row,
    input  logic [BANKS*DATA_WIDTH-1:0]   init_data,
    input  logic                          rd_step,
    input  logic [ROW_W-1:0]              rd_row,
    output logic [BANKS*DATA_WIDTH-1:0]   rd_data,
    output logic [BANKS-1:0]              rd_written,
    output logic                          rd_vld,
    output logic                          err_oob,
    output logic                          err_coll
);

    localparam int DEPTH = 2 ** ROW_W;
    localparam int AW    = ROW_W + BANK_W;
    localparam logic [BANK_W:0] BANK_LIM = (BANK_W + 1)'(BANKS);

    logic [DATA_WIDTH-1:0] mem   [DEPTH][BANKS];
    logic [BANKS-1:0]      wflag [DEPTH];

    logic [ROW_W-1:0]      w_row  [WPORTS];
    logic [BANK_W-1:0]     w_bank [WPORTS];
    logic [DATA_WIDTH-1:0] w_data [WPORTS];
    logic [WPORTS-1:0]     w_in;
    logic [WPORTS-1:0]     w_oob;
    logic                  coll_now;

    logic [ROW_W-1:0]            rd_row_q;
    logic [BANKS*DATA_WIDTH-1:0] row_data;

    // Unpack each write port into row, bank, record and an in-range qualifier.
    for (genvar p = 0; p < WPORTS; p++) begin : g_port
        assign w_row[p]  = wr_addr[p*AW+BANK_W +: ROW_W];
        assign w_bank[p] = wr_addr[p*AW +: BANK_W];
        assign w_data[p] = wr_data[p*DATA_WIDTH +: DATA_WIDTH];
        assign w_in[p]   = wr_en[p] &&  ({1'b0, w_bank[p]} < BANK_LIM);
        assign w_oob[p]  = wr_en[p] && !({1'b0, w_bank[p]} < BANK_LIM);
    end

    // Flag any pair of enabled ports aiming at the same (row,bank) this cycle.
    always_comb begin
        // NOTE: a default before the loops keeps this purely combinational; without it the flag would hold its value and infer a latch.
        coll_now = 1'b0;
        for (int p = 0; p < WPORTS; p++) begin
            for (int q = p + 1; q < WPORTS; q++) begin
                if (wr_en[p] && wr_en[q] && (wr_addr[p*AW +: AW] == wr_addr[q*AW +: AW]))
                    coll_now = 1'b1;
            end
        end
    end

    // Record storage: ports in ascending order so the highest index wins, row init last so it wins over all.
    // NOTE: the record array has no reset; only the written flags need a known state, and leaving the storage unreset lets it map onto plain RAM.
    always_ff @(posedge clk) begin
        for (int p = 0; p < WPORTS; p++) begin
            if (w_in[p])
                mem[w_row[p]][w_bank[p]] <= w_data[p];
        end
        if (init_en) begin
            for (int k = 0; k < BANKS; k++)
                mem[init_row][k] <= init_data[k*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    // Written flags: set by accepted port writes, cleared for the whole row by init.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values and the last assignment in program order wins.
            for (int r = 0; r < DEPTH; r++)
                wflag[r] <= '0;
        end else begin
            for (int p = 0; p < WPORTS; p++) begin
                if (w_in[p])
                    wflag[w_row[p]][w_bank[p]] <= 1'b1;
            end
            if (init_en)
                wflag[init_row] <= '0;
        end
    end

    // Sticky error reporting, cleared only by reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_oob  <= 1'b0;
            err_coll <= 1'b0;
        end else begin
            if (|w_oob)
                err_oob <= 1'b1;
            if (coll_now)
                err_coll <= 1'b1;
        end
    end

    // Retire row latch; rd_step=0 holds the current row.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            rd_row_q <= '0;
        else if (rd_step)
            rd_row_q <= rd_row;
    end

    for (genvar k = 0; k < BANKS; k++) begin : g_row
        assign row_data[k*DATA_WIDTH +: DATA_WIDTH] = mem[rd_row_q][k];
    end

    if (READ_REG == 0) begin : g_comb_rd
        logic seen;

        // rd_vld rises after the first rd_step and stays up until reset.
        always_ff @(posedge clk or negedge rst) begin
            if (!rst)
                seen <= 1'b0;
            else if (rd_step)
                seen <= 1'b1;
        end

        assign rd_data    = row_data;
        assign rd_written = wflag[rd_row_q];
        assign rd_vld     = seen;
    end else begin : g_reg_rd
        logic                        step_d1;
        logic                        vld_q;
        logic [BANKS*DATA_WIDTH-1:0] data_q;
        logic [BANKS-1:0]            written_q;

        // Output register refreshed every cycle; rd_vld is rd_step delayed two cycles.
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                step_d1   <= 1'b0;
                vld_q     <= 1'b0;
                data_q    <= '0;
                written_q <= '0;
            end else begin
                step_d1   <= rd_step;
                vld_q     <= step_d1;
                data_q    <= row_data;
                written_q <= wflag[rd_row_q];
            end
        end

        assign rd_data    = data_q;
        assign rd_written = written_q;
        assign rd_vld     = vld_q;
    end

endmodule

// File: tb/tb_bob_except_banked.sv
// Scoreboard bench for bob_except_banked: one instance per read mode, shared
// stimulus, a row/bank array model producing per-cycle expectations.

module tb_bob_except_banked;

    localparam int DW     = 16;
    localparam int BANKS  = 10;
    localparam int ROW_W  = 6;
    localparam int BANK_W = 4;
    localparam int WPORTS = 9;
    localparam int DEPTH  = 64;
    localparam int AW     = ROW_W + BANK_W;

    logic                    clk = 1'b0;
    logic                    rst;
    logic [WPORTS-1:0]       wr_en;
    logic [WPORTS*AW-1:0]    wr_addr;
    logic [WPORTS*DW-1:0]    wr_data;
    logic                    init_en;
    logic [ROW_W-1:0]        init_row;
    logic [BANKS*DW-1:0]     init_data;
    logic                    rd_step;
    logic [ROW_W-1:0]        rd_row;

    logic [BANKS*DW-1:0]     rd_data0, rd_data1;
    logic [BANKS-1:0]        rd_written0, rd_written1;
    logic                    rd_vld0, rd_vld1;
    logic                    err_oob0, err_oob1, err_coll0, err_coll1;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    bob_except_banked #(.DATA_WIDTH(DW), .BANKS(BANKS), .ROW_W(ROW_W), .BANK_W(BANK_W),
                        .WPORTS(WPORTS), .READ_REG(0)) dut0 (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .init_en(init_en), .init_row(init_row), .init_data(init_data),
        .rd_step(rd_step), .rd_row(rd_row), .rd_data(rd_data0), .rd_written(rd_written0),
        .rd_vld(rd_vld0), .err_oob(err_oob0), .err_coll(err_coll0));

    bob_except_banked #(.DATA_WIDTH(DW), .BANKS(BANKS), .ROW_W(ROW_W), .BANK_W(BANK_W),
                        .WPORTS(WPORTS), .READ_REG(1)) dut1 (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .init_en(init_en), .init_row(init_row), .init_data(init_data),
        .rd_step(rd_step), .rd_row(rd_row), .rd_data(rd_data1), .rd_written(rd_written1),
        .rd_vld(rd_vld1), .err_oob(err_oob1), .err_coll(err_coll1));

    typedef struct {
        bit                  vld0;
        logic [BANKS*DW-1:0] data0;
        logic [BANKS*DW-1:0] mask0;
        logic [BANKS-1:0]    wr0;
        bit                  vld1;
        logic [BANKS*DW-1:0] data1;
        logic [BANKS*DW-1:0] mask1;
        logic [BANKS-1:0]    wr1;
        bit                  oob;
        bit                  coll;
    } exp_t;

    exp_t exp_q[$];

    // Reference model: the store as a plain 2-D array plus per-entry flags.
    logic [DW-1:0]       m_mem   [DEPTH][BANKS];
    bit                  m_known [DEPTH][BANKS];
    bit                  m_wr    [DEPTH][BANKS];
    int                  m_row;
    bit                  m_vld0, m_step_d1, m_vld1, m_oob, m_coll;
    logic [BANKS*DW-1:0] m_d1, m_k1;
    logic [BANKS-1:0]    m_w1;

    task automatic check(input string name, input logic [BANKS*DW-1:0] act,
                         input logic [BANKS*DW-1:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    function automatic logic [DW-1:0] bank_of(input logic [BANKS*DW-1:0] v, input int k);
        return v[k*DW +: DW];
    endfunction

    task automatic snap(input int r, output logic [BANKS*DW-1:0] d,
                        output logic [BANKS*DW-1:0] k, output logic [BANKS-1:0] w);
        for (int b = 0; b < BANKS; b++) begin
            d[b*DW +: DW] = m_known[r][b] ? m_mem[r][b] : '0;
            k[b*DW +: DW] = m_known[r][b] ? '1 : '0;
            w[b]          = m_wr[r][b];
        end
    endtask

    task automatic model_reset();
        m_row = 0; m_vld0 = 0; m_step_d1 = 0; m_vld1 = 0; m_oob = 0; m_coll = 0;
        m_d1 = '0; m_k1 = '0; m_w1 = '0;
        for (int r = 0; r < DEPTH; r++)
            for (int b = 0; b < BANKS; b++)
                m_wr[r][b] = 0;
    endtask

    // Apply this cycle's inputs to the model and queue what both DUTs must show after the edge.
    task automatic commit();
        exp_t                e;
        logic [BANKS*DW-1:0] d, k;
        logic [BANKS-1:0]    w;
        int                  row, bank;
        snap(m_row, d, k, w);
        m_d1 = d; m_k1 = k; m_w1 = w;
        m_vld1    = m_step_d1;
        m_step_d1 = rd_step;
        for (int p = 0; p < WPORTS; p++) begin
            if (wr_en[p] && wr_addr[p*AW +: BANK_W] >= BANKS) m_oob = 1;
            for (int q = p + 1; q < WPORTS; q++)
                if (wr_en[p] && wr_en[q] && wr_addr[p*AW +: AW] == wr_addr[q*AW +: AW]) m_coll = 1;
        end
        for (int p = 0; p < WPORTS; p++) begin
            row  = int'(wr_addr[p*AW+BANK_W +: ROW_W]);
            bank = int'(wr_addr[p*AW +: BANK_W]);
            if (wr_en[p] && bank < BANKS) begin
                m_mem[row][bank]   = wr_data[p*DW +: DW];
                m_known[row][bank] = 1;
                m_wr[row][bank]    = 1;
            end
        end
        if (init_en) begin
            for (int b = 0; b < BANKS; b++) begin
                m_mem[init_row][b]   = init_data[b*DW +: DW];
                m_known[init_row][b] = 1;
                m_wr[init_row][b]    = 0;
            end
        end
        if (rd_step) begin
            m_row  = int'(rd_row);
            m_vld0 = 1;
        end
        snap(m_row, d, k, w);
        e.vld0 = m_vld0; e.data0 = d; e.mask0 = k; e.wr0 = w;
        e.vld1 = m_vld1; e.data1 = m_d1; e.mask1 = m_k1; e.wr1 = m_w1;
        e.oob = m_oob; e.coll = m_coll;
        exp_q.push_back(e);
    endtask

    task automatic idle();
        wr_en = '0; init_en = 1'b0; rd_step = 1'b0;
    endtask

    task automatic next();
        commit();
        @(negedge clk);
        idle();
    endtask

    task automatic set_port(input int p, input int row, input int bank, input int data);
        wr_en[p] = 1'b1;
        wr_addr[p*AW +: AW] = {ROW_W'(row), BANK_W'(bank)};
        wr_data[p*DW +: DW] = DW'(data);
    endtask

    task automatic set_init(input int row, input bit rand_data);
        init_en  = 1'b1;
        init_row = ROW_W'(row);
        for (int k = 0; k < BANKS; k++)
            init_data[k*DW +: DW] = rand_data ? DW'($urandom) : DW'(k + 1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_vld0"}, rd_vld0, 0);
        check({tag, "_vld1"}, rd_vld1, 0);
        check({tag, "_wr0"}, rd_written0, 0);
        check({tag, "_wr1"}, rd_written1, 0);
        check({tag, "_data1"}, rd_data1, 0);
        check({tag, "_oob"}, {err_oob0, err_oob1}, 0);
        check({tag, "_coll"}, {err_coll0, err_coll1}, 0);
    endtask

    task automatic random_cycles(input int n);
        int p_oob, row;
        for (int c = 0; c < n; c++) begin
            p_oob = ($urandom_range(0, 15) == 0) ? $urandom_range(0, WPORTS - 1) : -1;
            for (int p = 0; p < WPORTS; p++) begin
                if ($urandom_range(0, 2) == 0) begin
                    row = ($urandom_range(0, 3) == 0) ? $urandom_range(0, DEPTH - 1) : $urandom_range(0, 3);
                    set_port(p, row, (p == p_oob) ? $urandom_range(BANKS, 15) : $urandom_range(0, BANKS - 1),
                             $urandom);
                end
            end
            if ($urandom_range(0, 7) == 0) set_init($urandom_range(0, 3), 1);
            if ($urandom_range(0, 1) == 0) begin
                rd_step = 1'b1;
                rd_row  = ROW_W'($urandom_range(0, 3));
            end
            next();
        end
    endtask

    // Monitor: just after each edge, pop the expectation queued for it and compare both DUTs.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("vld0", rd_vld0, e.vld0);
                if (e.vld0) begin
                    check("data0", rd_data0 & e.mask0, e.data0);
                    check("written0", rd_written0, e.wr0);
                end
                check("vld1", rd_vld1, e.vld1);
                if (e.vld1) begin
                    check("data1", rd_data1 & e.mask1, e.data1);
                    check("written1", rd_written1, e.wr1);
                end
                check("err_oob", {err_oob0, err_oob1}, {e.oob, e.oob});
                check("err_coll", {err_coll0, err_coll1}, {e.coll, e.coll});
            end
        end
    end

    initial begin
        logic [BANKS*DW-1:0] req, d63, d0;
        logic [DW-1:0]       init_b0;

        idle();
        rst = 1'b0; wr_addr = '0; wr_data = '0; init_row = '0; init_data = '0; rd_row = '0;
        model_reset();
        repeat (2) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b1;

        // Row init with k+1 per bank, then read it back.
        set_init(5, 0);
        next();
        rd_step = 1'b1; rd_row = 6'd5;
        next();
        for (int k = 0; k < BANKS; k++) req[k*DW +: DW] = DW'(k + 1);
        check("t1_vld", rd_vld0, 1);
        check("t1_data", rd_data0, req);
        check("t1_written", rd_written0, 0);

        // Two ports on the same entry: higher port wins, collision flagged.
        set_port(0, 5, 2, 'hA);
        set_port(3, 5, 2, 'hB);
        next();
        check("t2_bank2", bank_of(rd_data0, 2), 'hB);
        check("t2_written2", rd_written0[2], 1);
        check("t2_coll", err_coll0, 1);

        // Bank beyond the row is dropped and flagged.
        set_port(1, 5, 12, 'h55);
        next();
        check("t3_oob", err_oob0, 1);
        check("t3_data", rd_data0, {req[BANKS*DW-1:3*DW], DW'('hB), req[2*DW-1:0]});

        // Init overrides a same-cycle port write to its row.
        set_init(7, 1);
        init_b0 = init_data[DW-1:0];
        set_port(4, 7, 0, 'h77);
        next();
        rd_step = 1'b1; rd_row = 6'd7;
        next();
        check("t4_bank0", bank_of(rd_data0, 0), init_b0);
        check("t4_written0", rd_written0[0], 0);

        // Registered read: two-cycle pulse, row 63 then wrap to row 0.
        set_init(63, 1); d63 = init_data;
        next();
        set_init(0, 1); d0 = init_data;
        next();
        rd_step = 1'b1; rd_row = 6'd63;
        next();
        check("t5_vld1_early", rd_vld1, 0);
        rd_step = 1'b1; rd_row = 6'd0;
        next();
        check("t5_vld1_r63", rd_vld1, 1);
        check("t5_data1_r63", rd_data1, d63);
        next();
        check("t5_vld1_r0", rd_vld1, 1);
        check("t5_data1_r0", rd_data1, d0);
        next();
        check("t5_vld1_end", rd_vld1, 0);

        random_cycles(400);

        // Asynchronous reset mid-run, then re-read row 5.
        rst = 1'b0;
        #1;
        check_reset_outputs("midrst");
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        rd_step = 1'b1; rd_row = 6'd5;
        next();
        check("t6_vld", rd_vld0, 1);
        check("t6_written", rd_written0, 0);

        random_cycles(300);
        next();
        next();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
